// File: rtl/seg7_scan_ctrl.sv
// Wishbone-programmable scan scheduler for an 8-digit multiplexed seven-segment display.
// Drives one digit at a time for a programmable dwell, with a fixed blanking gap between digits.
module seg7_scan_ctrl #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned DIV_W        = 20
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [7:0]  o_an,
  output logic [6:0]  o_seg
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_BLANK} state_t;

  logic [8:0]       ctrl_q;
  logic [31:0]      data_q;
  logic [DIV_W-1:0] div_q;
  state_t           state;
  logic [2:0]       idx;
  logic [DIV_W-1:0] cnt;

  logic [7:0]       en;
  logic             gen;
  logic             wb_req;
  logic [DIV_W-1:0] dwell_last;
  logic [DIV_W-1:0] blank_last;
  logic             unused_ok;

  assign en         = ctrl_q[7:0];
  assign gen        = ctrl_q[8];
  assign wb_req     = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign dwell_last = (div_q < DIV_W'(2)) ? DIV_W'(1) : div_q - DIV_W'(1);
  assign blank_last = DIV_W'(BLANK_CYCLES - 1);
  assign unused_ok  = ^i_wb_adr[1:0];

  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] dat,
                                         input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[2'(b)]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b0000001;
      4'h1: decode = 7'b1001111;
      4'h2: decode = 7'b0010010;
      4'h3: decode = 7'b0000110;
      4'h4: decode = 7'b1001100;
      4'h5: decode = 7'b0100100;
      4'h6: decode = 7'b0100000;
      4'h7: decode = 7'b0001111;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0000100;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b1100000;
      4'hC: decode = 7'b0110001;
      4'hD: decode = 7'b1000010;
      4'hE: decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  function automatic logic [2:0] first_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (m[3'(i)]) r = 3'(i);
    return r;
  endfunction

  // Nearest set bit strictly after cur, circularly; falls back to cur itself.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] j;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      j = cur + 3'(i);
      if (m[j]) r = j;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [31:0] d, input logic [2:0] k);
    return decode(d[{k, 2'b00} +: 4]);
  endfunction

  // Register file and single-cycle Wishbone handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wb_ack <= 1'b0;
      o_wb_rdt <= 32'd0;
      ctrl_q   <= 9'd0;
      data_q   <= 32'd0;
      div_q    <= DIV_W'(SCAN_DIV);
    end else begin
      o_wb_ack <= wb_req;
      o_wb_rdt <= 32'd0;
      if (wb_req && i_wb_we) begin
        case (i_wb_adr[3:2])
          2'd0:    ctrl_q <= 9'(wmerge(32'(ctrl_q), i_wb_dat, i_wb_sel));
          2'd1:    data_q <= wmerge(data_q, i_wb_dat, i_wb_sel);
          2'd2:    div_q  <= DIV_W'(wmerge(32'(div_q), i_wb_dat, i_wb_sel));
          default: ;
        endcase
      end
      if (wb_req && !i_wb_we) begin
        case (i_wb_adr[3:2])
          2'd0:    o_wb_rdt <= 32'(ctrl_q);
          2'd1:    o_wb_rdt <= data_q;
          2'd2:    o_wb_rdt <= 32'(div_q);
          default: o_wb_rdt <= 32'd0;
        endcase
      end
    end
  end

  // Scan FSM; outputs are updated on the same edge as the state they belong to.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      idx   <= 3'd0;
      cnt   <= '0;
      o_an  <= 8'hFF;
      o_seg <= 7'h7F;
    end else if (!gen || en == 8'd0) begin
      state <= ST_IDLE;
      cnt   <= '0;
      o_an  <= 8'hFF;
      o_seg <= 7'h7F;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_DRIVE;
          idx   <= first_set(en);
          cnt   <= '0;
          o_an  <= ~(8'd1 << first_set(en));
          o_seg <= digit_seg(data_q, first_set(en));
        end
        ST_DRIVE: begin
          if (!en[idx] || cnt >= dwell_last) begin
            state <= ST_BLANK;
            cnt   <= '0;
            o_an  <= 8'hFF;
            o_seg <= 7'h7F;
          end else begin
            cnt   <= cnt + DIV_W'(1);
            o_an  <= ~(8'd1 << idx);
            o_seg <= digit_seg(data_q, idx);
          end
        end
        ST_BLANK: begin
          if (cnt >= blank_last) begin
            state <= ST_DRIVE;
            idx   <= next_set(en, idx);
            cnt   <= '0;
            o_an  <= ~(8'd1 << next_set(en, idx));
            o_seg <= digit_seg(data_q, next_set(en, idx));
          end else begin
            cnt   <= cnt + DIV_W'(1);
            o_an  <= 8'hFF;
            o_seg <= 7'h7F;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          o_an  <= 8'hFF;
          o_seg <= 7'h7F;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: expected scan traces are built from the enabled-digit
// list, dwell and blank lengths, then compared cycle by cycle against o_an/o_seg.
module tb_seg7_scan_ctrl;

  localparam int unsigned BLANK    = 16;
  localparam int unsigned SCAN_DIV = 50000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic [7:0]  an;
  logic [6:0]  seg;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  logic [7:0] q_an[$];
  logic [6:0] q_seg[$];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK_CYCLES(BLANK), .DIV_W(20)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(wb_adr), .i_wb_dat(wb_dat), .i_wb_sel(wb_sel),
    .i_wb_we(wb_we), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .o_wb_rdt(wb_rdt),
    .o_wb_ack(wb_ack), .o_an(an), .o_seg(seg)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab[16];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
            7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return tab[v];
  endfunction

  // Called and returning on a falling edge; a1 is the ack level one cycle after the ack.
  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdt,
                         output logic a0, output logic a1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
    @(posedge clk); #1;
    a0  = wb_ack;
    rdt = wb_rdt;
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(posedge clk); #1;
    a1 = wb_ack;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] r;
    logic a0, a1;
    wb_xfer(1'b1, adr, dat, sel, r, a0, a1);
  endtask

  task automatic wb_read(input logic [3:0] adr, output logic [31:0] rdt);
    logic a0, a1;
    wb_xfer(1'b0, adr, 32'd0, 4'h0, rdt, a0, a1);
  endtask

  // Expected scan: enabled digits in ascending circular order, each dwell then a blank gap.
  task automatic build_trace(input logic [7:0] en, input int unsigned div, input logic [31:0] data,
                             input int unsigned slots);
    int order[$];
    int unsigned eff;
    int d;
    logic [31:0] dv;
    for (int k = 0; k < 8; k++) if (en[k]) order.push_back(k);
    eff = (div < 2) ? 2 : div;
    for (int unsigned s = 0; s < slots; s++) begin
      d  = order[s % order.size()];
      dv = data >> (4 * d);
      for (int unsigned c = 0; c < eff; c++) begin
        q_an.push_back(~(8'd1 << d));
        q_seg.push_back(seg_of(dv[3:0]));
      end
      for (int unsigned c = 0; c < BLANK; c++) begin
        q_an.push_back(8'hFF);
        q_seg.push_back(7'h7F);
      end
    end
  endtask

  task automatic push_blank(input int unsigned n);
    for (int unsigned c = 0; c < n; c++) begin
      q_an.push_back(8'hFF);
      q_seg.push_back(7'h7F);
    end
  endtask

  task automatic check_trace(input string name);
    logic [7:0] ea;
    logic [6:0] es;
    int unsigned cyc;
    cyc = 0;
    while (q_an.size() > 0) begin
      ea = q_an.pop_front();
      es = q_seg.pop_front();
      vecs++;
      if (an !== ea || seg !== es) begin
        errs++;
        $display("FAIL %s cycle %0d: an=%h seg=%b, expected an=%h seg=%b", name, cyc, an, seg, ea, es);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic a0, a1;
    logic [31:0] exp_rd[4];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vecs++;
    if (an !== 8'hFF || seg !== 7'h7F || wb_ack !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: an=%h seg=%b ack=%b, expected FF 1111111 0", an, seg, wb_ack);
    end
    exp_rd = '{32'd0, 32'd0, 32'(SCAN_DIV), 32'd0};
    for (int k = 0; k < 4; k++) begin
      wb_xfer(1'b0, 4'(4 * k), 32'd0, 4'h0, r, a0, a1);
      vecs++;
      if (r !== exp_rd[k] || a0 !== 1'b1 || a1 !== 1'b0) begin
        errs++;
        $display("FAIL reset_read_%0d: rdt=%h ack=%b%b, expected rdt=%h ack=10", k, r, a0, a1, exp_rd[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic exp_ack;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h8;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      exp_ack = (i % 2 == 0);
      vecs++;
      if (wb_ack !== exp_ack || (exp_ack && wb_rdt !== 32'(SCAN_DIV))) begin
        errs++;
        $display("FAIL back_to_back beat %0d: ack=%b rdt=%h, expected ack=%b", i, wb_ack, wb_rdt, exp_ack);
      end
    end
    @(negedge clk);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_scan();
    wb_write(4'h8, 32'd4, 4'hF);
    wb_write(4'h4, 32'h76543210, 4'hF);
    wb_write(4'h0, 32'h1FF, 4'hF);
    build_trace(8'hFF, 4, 32'h76543210, 9);
    check_trace("scan_all");
    wb_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_mask();
    wb_write(4'h8, 32'd3, 4'hF);
    wb_write(4'h0, 32'h181, 4'hF);
    build_trace(8'h81, 3, 32'h76543210, 4);
    check_trace("mask_0_7");
    wb_write(4'h0, 32'h0, 4'hF);
    wb_write(4'h0, 32'h104, 4'hF);
    build_trace(8'h04, 3, 32'h76543210, 2);
    check_trace("mask_single");
    wb_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_random();
    int unsigned div;
    logic [31:0] data;
    logic [7:0]  en;
    int unsigned slots;
    for (int it = 0; it < 5; it++) begin
      div  = $urandom_range(0, 6);
      data = $urandom;
      en   = 8'($urandom_range(1, 255));
      slots = 1;
      for (int k = 0; k < 8; k++) if (en[k]) slots++;
      wb_write(4'h8, 32'(div), 4'hF);
      wb_write(4'h4, data, 4'hF);
      wb_write(4'h0, {23'd0, 1'b1, en}, 4'hF);
      build_trace(en, div, data, slots);
      check_trace("random_scan");
      wb_write(4'h0, 32'h0, 4'hF);
      push_blank(3);
      check_trace("random_stop");
    end
  endtask

  task automatic test_disable();
    logic [31:0] data;
    data = 32'h89ABCDEF;
    wb_write(4'h8, 32'd30, 4'hF);
    wb_write(4'h4, data, 4'hF);
    wb_write(4'h0, 32'h1FC, 4'hF);
    vecs++;
    if (an !== 8'hFB || seg !== seg_of(4'hD)) begin
      errs++;
      $display("FAIL disable_start: an=%h seg=%b, expected FB %b", an, seg, seg_of(4'hD));
    end
    wb_write(4'h0, 32'h1F8, 4'hF);
    push_blank(BLANK);
    for (int c = 0; c < 5; c++) begin
      q_an.push_back(8'hF7);
      q_seg.push_back(seg_of(4'hC));
    end
    check_trace("en_clear");
    wb_write(4'h0, 32'h0F8, 4'hF);
    push_blank(6);
    check_trace("gen_clear");
  endtask

  task automatic test_sel();
    logic [31:0] r;
    wb_write(4'h0, 32'h0, 4'hF);
    wb_write(4'h4, 32'h0, 4'hF);
    wb_write(4'h8, 32'd30, 4'hF);
    wb_write(4'h0, 32'h104, 4'hF);
    wb_write(4'h4, 32'hFFFFFFFF, 4'b0010);
    vecs++;
    if (an !== 8'hFB || seg !== 7'b0111000) begin
      errs++;
      $display("FAIL sel_digit: an=%h seg=%b, expected FB 0111000", an, seg);
    end
    wb_read(4'h4, r);
    vecs++;
    if (r !== 32'h0000FF00) begin
      errs++;
      $display("FAIL sel_read: rdt=%h, expected 0000ff00", r);
    end
    wb_write(4'h0, 32'h0, 4'hF);
    wb_write(4'h8, 32'd0, 4'hF);
    wb_write(4'h0, 32'h111, 4'hF);
    build_trace(8'h11, 0, 32'h0000FF00, 3);
    check_trace("div_zero");
    wb_write(4'h0, 32'h0, 4'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    wb_write(4'h4, 32'h12345678, 4'hF);
    wb_write(4'h8, 32'd30, 4'hF);
    wb_write(4'h0, 32'h1FF, 4'hF);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vecs++;
    if (an !== 8'hFF || seg !== 7'h7F) begin
      errs++;
      $display("FAIL mid_reset_out: an=%h seg=%b, expected FF 1111111", an, seg);
    end
    wb_read(4'h0, r);
    vecs++;
    if (r !== 32'd0) begin errs++; $display("FAIL mid_reset_ctrl: rdt=%h, expected 0", r); end
    wb_read(4'h4, r);
    vecs++;
    if (r !== 32'd0) begin errs++; $display("FAIL mid_reset_data: rdt=%h, expected 0", r); end
    wb_read(4'h8, r);
    vecs++;
    if (r !== 32'(SCAN_DIV)) begin
      errs++;
      $display("FAIL mid_reset_div: rdt=%h, expected %h", r, 32'(SCAN_DIV));
    end
    push_blank(40);
    check_trace("mid_reset_idle");
  endtask

  initial begin
    rst = 1'b1; wb_adr = 4'h0; wb_dat = 32'd0; wb_sel = 4'h0;
    wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_scan();
    test_mask();
    test_random();
    test_disable();
    test_sel();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
